// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one host memory port (req / wr / rd) between two
// memory clients. One whole transaction (request plus len+1 beats) is
// granted at a time, with round-robin choice when both clients ask at once.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  // client 0
  input  logic                     c0_req_valid,
  output logic                     c0_req_ready,
  input  logic                     c0_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
  input  logic                     c0_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
  output logic                     c0_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
  input  logic                     c0_rd_ready,
  // client 1
  input  logic                     c1_req_valid,
  output logic                     c1_req_ready,
  input  logic                     c1_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
  input  logic                     c1_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
  output logic                     c1_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
  input  logic                     c1_rd_ready,
  // host memory port
  output logic                     mem_req_valid,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  input  logic                     mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     mem_rd_ready,
  // status
  output logic                     busy,
  output logic                     grant
);

  typedef enum logic [1:0] {IDLE, REQ, RD_DATA, WR_DATA} state_t;

  localparam logic [MEM_LEN_BITS-1:0] LEN_ONE = 1;

  state_t                   state;
  logic                     last_grant;
  logic [MEM_LEN_BITS-1:0]  beat_cnt;
  logic                     opcode_q;
  logic [MEM_LEN_BITS-1:0]  len_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;

  logic any_req;
  logic winner;
  logic take;
  logic in_rd;
  logic in_wr;
  logic rd_fire;
  logic last_beat;

  // Round-robin winner: a lone requester wins, a tie goes away from last_grant
  always_comb begin
    any_req = c0_req_valid | c1_req_valid;
    winner  = c1_req_valid;
    if (c0_req_valid && c1_req_valid) begin
      winner = ~last_grant;
    end
  end

  assign take         = (state == IDLE) & any_req;
  assign c0_req_ready = take & ~winner;
  assign c1_req_ready = take & winner;

  assign busy  = (state != IDLE);
  assign grant = last_grant;
  assign in_rd = (state == RD_DATA);
  assign in_wr = (state == WR_DATA);

  // Request fields only leave the arbiter during the single REQ cycle
  assign mem_req_valid  = (state == REQ);
  assign mem_req_opcode = mem_req_valid & opcode_q;
  assign mem_req_len    = mem_req_valid ? len_q  : '0;
  assign mem_req_addr   = mem_req_valid ? addr_q : '0;

  // Read beats are steered to the granted client only
  assign mem_rd_ready = in_rd & (last_grant ? c1_rd_ready : c0_rd_ready);
  assign c0_rd_valid  = in_rd & ~last_grant & mem_rd_valid;
  assign c1_rd_valid  = in_rd &  last_grant & mem_rd_valid;
  assign c0_rd_bits   = (in_rd & ~last_grant) ? mem_rd_bits : '0;
  assign c1_rd_bits   = (in_rd &  last_grant) ? mem_rd_bits : '0;
  assign rd_fire      = mem_rd_valid & mem_rd_ready;

  // Write beats come only from the granted client
  assign mem_wr_valid = in_wr & (last_grant ? c1_wr_valid : c0_wr_valid);
  assign mem_wr_bits  = mem_wr_valid ? (last_grant ? c1_wr_bits : c0_wr_bits) : '0;

  assign last_beat = (beat_cnt == len_q);

  // Transaction control: grant, one request cycle, then len+1 data beats
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= winner;
            beat_cnt   <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          state <= opcode_q ? WR_DATA : RD_DATA;
        end
        RD_DATA: begin
          if (rd_fire) begin
            if (last_beat) state <= IDLE;
            else           beat_cnt <= beat_cnt + LEN_ONE;
          end
        end
        WR_DATA: begin
          if (mem_wr_valid) begin
            if (last_beat) state <= IDLE;
            else           beat_cnt <= beat_cnt + LEN_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the winner's request fields at grant; later client changes are ignored
  always_ff @(posedge clock) begin
    if (take) begin
      opcode_q <= winner ? c1_req_opcode : c0_req_opcode;
      len_q    <= winner ? c1_req_len    : c0_req_len;
      addr_q   <= winner ? c1_req_addr   : c0_req_addr;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of grant scenarios plus hand-written
// sequences, with a scoreboard of expected requests, write beats and read beats.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        c0_req_valid, c0_req_ready, c0_req_opcode;
  logic [7:0]  c0_req_len;
  logic [63:0] c0_req_addr;
  logic        c0_wr_valid;
  logic [63:0] c0_wr_bits;
  logic        c0_rd_valid;
  logic [63:0] c0_rd_bits;
  logic        c0_rd_ready;
  logic        c1_req_valid, c1_req_ready, c1_req_opcode;
  logic [7:0]  c1_req_len;
  logic [63:0] c1_req_addr;
  logic        c1_wr_valid;
  logic [63:0] c1_wr_bits;
  logic        c1_rd_valid;
  logic [63:0] c1_rd_bits;
  logic        c1_rd_ready;
  logic        mem_req_valid, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_bits;
  logic        mem_rd_ready;
  logic        busy, grant;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready),
    .c0_req_opcode(c0_req_opcode), .c0_req_len(c0_req_len), .c0_req_addr(c0_req_addr),
    .c0_wr_valid(c0_wr_valid), .c0_wr_bits(c0_wr_bits),
    .c0_rd_valid(c0_rd_valid), .c0_rd_bits(c0_rd_bits), .c0_rd_ready(c0_rd_ready),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
    .c1_req_opcode(c1_req_opcode), .c1_req_len(c1_req_len), .c1_req_addr(c1_req_addr),
    .c1_wr_valid(c1_wr_valid), .c1_wr_bits(c1_wr_bits),
    .c1_rd_valid(c1_rd_valid), .c1_rd_bits(c1_rd_bits), .c1_rd_ready(c1_rd_ready),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
    .busy(busy), .grant(grant)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;

  typedef struct packed {
    logic        g;
    logic        op;
    logic [7:0]  len;
    logic [63:0] addr;
  } req_t;

  typedef struct packed {
    logic        g;
    logic [63:0] d;
  } rd_t;

  typedef struct {
    bit          pre_rst;
    bit          v0, v1, op0, op1;
    logic [7:0]  l0, l1;
    logic [63:0] a0, a1;
    bit          eg;
    logic [63:0] base;
    int          dly;
  } vec_t;

  req_t exp_req[$];
  logic [63:0] exp_wr[$];
  rd_t  exp_rd[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(bit pr, bit v0, bit v1, bit op0, bit op1,
                              logic [7:0] l0, logic [7:0] l1,
                              logic [63:0] a0, logic [63:0] a1,
                              bit eg, logic [63:0] base, int dly);
    vec_t v;
    v.pre_rst = pr; v.v0 = v0; v.v1 = v1; v.op0 = op0; v.op1 = op1;
    v.l0 = l0; v.l1 = l1; v.a0 = a0; v.a1 = a1; v.eg = eg; v.base = base; v.dly = dly;
    return v;
  endfunction

  // Scoreboard monitor: pops expectations when the DUT shows traffic
  req_t er;
  rd_t  rr;
  logic [63:0] ew;
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req_valid) begin
        if (exp_req.size() == 0) check("req_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_req.pop_front();
          check("req_grant", 64'(grant), 64'(er.g));
          check("req_opcode", 64'(mem_req_opcode), 64'(er.op));
          check("req_len", 64'(mem_req_len), 64'(er.len));
          check("req_addr", mem_req_addr, er.addr);
        end
      end
      if (mem_wr_valid) begin
        wr_count++;
        if (exp_wr.size() == 0) check("wr_unexpected", mem_wr_bits, 64'd0);
        else begin
          ew = exp_wr.pop_front();
          check("wr_bits", mem_wr_bits, ew);
        end
      end
      if (c0_rd_valid) check("c1_rd_quiet", 64'(c1_rd_valid), 64'd0);
      if ((c0_rd_valid && c0_rd_ready) || (c1_rd_valid && c1_rd_ready)) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else begin
          rr = exp_rd.pop_front();
          check("rd_client", 64'(c1_rd_valid), 64'(rr.g));
          check("rd_bits", c1_rd_valid ? c1_rd_bits : c0_rd_bits, rr.d);
        end
      end
      if (busy && (c0_req_ready || c1_req_ready)) check("ready_while_busy", 64'd1, 64'd0);
    end
  end

  // Accept step: inputs already driven; checks the winner's ready and queues its request
  task automatic grant_step(input bit eg);
    req_t r;
    #1;
    check("c0_req_ready", 64'(c0_req_ready), 64'(!eg));
    check("c1_req_ready", 64'(c1_req_ready), 64'(eg));
    r.g    = eg;
    r.op   = eg ? c1_req_opcode : c0_req_opcode;
    r.len  = eg ? c1_req_len    : c0_req_len;
    r.addr = eg ? c1_req_addr   : c0_req_addr;
    exp_req.push_back(r);
    tick();
    if (eg) begin c1_req_valid = 1'b0; c1_req_addr = 64'hBAD; c1_req_len = 8'hFF; end
    else    begin c0_req_valid = 1'b0; c0_req_addr = 64'hBAD; c0_req_len = 8'hFF; end
  endtask

  // Memory/client side of one transaction, from the REQ cycle to IDLE
  task automatic run_txn(input logic [63:0] base, input int delay, input int rdy_mode,
                         input bit intrude, input int abort_after);
    int  cyc, n, i, k;
    bit  g, op, r;
    rd_t e;
    cyc = 0;
    @(negedge clock);
    while (!mem_req_valid && cyc < 20) begin @(negedge clock); cyc++; end
    if (!mem_req_valid) begin
      check("req_timeout", 64'd0, 64'd1);
      return;
    end
    g = grant; op = mem_req_opcode; n = int'(mem_req_len) + 1;
    tick();
    if (op) begin
      for (i = 0; i < n; i++) begin
        if (g) begin c1_wr_valid = 1'b1; c1_wr_bits = base + 64'(i); end
        else   begin c0_wr_valid = 1'b1; c0_wr_bits = base + 64'(i); end
        if (intrude) begin
          if (g) begin c0_wr_valid = 1'b1; c0_wr_bits = 64'hDEAD; end
          else   begin c1_wr_valid = 1'b1; c1_wr_bits = 64'hDEAD; end
        end
        exp_wr.push_back(base + 64'(i));
        tick();
      end
      c0_wr_valid = 1'b0; c1_wr_valid = 1'b0;
    end else begin
      repeat (delay) tick();
      i = 0; k = 0;
      while (i < n && k < 64) begin
        if (abort_after == i) break;
        r = (rdy_mode == 0) ? 1'b1 : (k % 2 == 0);
        c0_rd_ready = g ? 1'b1 : r;
        c1_rd_ready = g ? r : 1'b1;
        mem_rd_valid = 1'b1; mem_rd_bits = base + 64'(i);
        #1;
        check("rd_ready_track", 64'(mem_rd_ready), 64'(r));
        if (r) begin e.g = g; e.d = base + 64'(i); exp_rd.push_back(e); end
        tick();
        if (r) i++;
        k++;
      end
      mem_rd_valid = 1'b0;
      if (abort_after >= 0) begin
        c0_rd_ready = 1'b0; c1_rd_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_bits = 64'h55;
        c0_rd_ready = 1'b1; c1_rd_ready = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_grant", 64'(grant), 64'd1);
        check("abort_req_valid", 64'(mem_req_valid), 64'd0);
        check("abort_req_addr", mem_req_addr, 64'd0);
        check("abort_req_len", 64'(mem_req_len), 64'd0);
        check("abort_wr_valid", 64'(mem_wr_valid), 64'd0);
        check("abort_wr_bits", mem_wr_bits, 64'd0);
        check("stray_rd_ready", 64'(mem_rd_ready), 64'd0);
        check("stray_c0_rd_valid", 64'(c0_rd_valid), 64'd0);
        tick();
        mem_rd_valid = 1'b0;
      end else if (i < n) begin
        check("rd_timeout", 64'(i), 64'(n));
      end
    end
    c0_rd_ready = 1'b0; c1_rd_ready = 1'b0;
    check("busy_end", 64'(busy), 64'd0);
  endtask

  vec_t vecs[9];
  vec_t v;
  int   w0;

  initial begin
    reset = 1'b1;
    c0_req_valid = 0; c0_req_opcode = 0; c0_req_len = 0; c0_req_addr = 0;
    c0_wr_valid = 0; c0_wr_bits = 0; c0_rd_ready = 0;
    c1_req_valid = 0; c1_req_opcode = 0; c1_req_len = 0; c1_req_addr = 0;
    c1_wr_valid = 0; c1_wr_bits = 0; c1_rd_ready = 0;
    mem_rd_valid = 0; mem_rd_bits = 0;

    //           pr    v0    v1    op0   op1   l0  l1  a0       a1       eg    base      dly
    vecs[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  64'h10,  64'h0,   1'b0, 64'hAA,   3);
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0,  1,  64'h30,  64'h20,  1'b0, 64'h100,  1);
    vecs[2] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0,  1,  64'h30,  64'h20,  1'b1, 64'h5,    0);
    for (int t = 3; t < 9; t++)
      vecs[t] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 64'h40 + 64'(t), 64'h80 + 64'(t),
                   (t % 2 == 0), 64'h1000 + 64'(t * 16), 0);

    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd1);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
    check("rst_rd_ready", 64'(mem_rd_ready), 64'd0);
    check("rst_c0_ready", 64'(c0_req_ready), 64'd0);

    for (int t = 0; t < 9; t++) begin
      v = vecs[t];
      if (v.pre_rst) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      c0_req_valid = v.v0; c0_req_opcode = v.op0; c0_req_len = v.l0; c0_req_addr = v.a0;
      c1_req_valid = v.v1; c1_req_opcode = v.op1; c1_req_len = v.l1; c1_req_addr = v.a1;
      grant_step(v.eg);
      run_txn(v.base, v.dly, 0, 1'b0, -1);
    end
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;

    // Read len=3 with client 0 ready toggling
    c0_req_valid = 1'b1; c0_req_opcode = 1'b0; c0_req_len = 8'd3; c0_req_addr = 64'h200;
    grant_step(1'b0);
    run_txn(64'h300, 1, 1, 1'b0, -1);

    // Client 1 write beats must not reach memory during client 0 write
    c0_req_valid = 1'b1; c0_req_opcode = 1'b1; c0_req_len = 8'd0; c0_req_addr = 64'h400;
    w0 = wr_count;
    grant_step(1'b0);
    run_txn(64'h77, 0, 0, 1'b1, -1);
    check("wr_count", 64'(wr_count - w0), 64'd1);

    // Reset after 2 of 4 read beats, then client 1 alone
    c0_req_valid = 1'b1; c0_req_opcode = 1'b0; c0_req_len = 8'd3; c0_req_addr = 64'h500;
    grant_step(1'b0);
    run_txn(64'h900, 0, 0, 1'b0, 2);
    c1_req_valid = 1'b1; c1_req_opcode = 1'b0; c1_req_len = 8'd0; c1_req_addr = 64'h600;
    grant_step(1'b1);
    run_txn(64'hA00, 0, 0, 1'b0, -1);

    repeat (3) tick();
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
